// File: rtl/booth_mult_seq_pkg.sv
// Shared multdiv definitions: FSM encoding and iteration count.
// Reused by the multdiv control block.
package booth_mult_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int XLEN       = 32;
  localparam int MULT_ITERS = 32;

endpackage

// File: rtl/adder_32.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups, rippled.
// ovf is signed overflow (carry into MSB xor carry out).
module adder_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout,
  output logic        ovf
);

  logic [31:0] g;
  logic [31:0] p;
  logic [32:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Lookahead carries inside each group, group carry rippled on.
  always_comb begin
    c = '0;
    c[0] = cin;
    for (int k = 0; k < 8; k++) begin
      c[4*k+1] = g[4*k]
               | (p[4*k] & c[4*k]);
      c[4*k+2] = g[4*k+1]
               | (p[4*k+1] & g[4*k])
               | (p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+3] = g[4*k+2]
               | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+4] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1]
                  & p[4*k] & c[4*k]);
    end
  end

  assign sum  = p ^ c[31:0];
  assign cout = c[32];
  assign ovf  = c[32] ^ c[31];

endmodule

// File: rtl/booth_mult_seq_step.sv
// One radix-2 Booth step: decode P[1:0], pick adder operand,
// then arithmetic-shift {hi, P[32:0]} right by one.
module booth_step
  import booth_mult_seq_pkg::*;
(
  input  logic [2*XLEN:0] p,
  input  logic [XLEN-1:0] m,
  input  logic [XLEN-1:0] sum,
  input  logic            ovf,
  output logic [XLEN-1:0] add_b,
  output logic            cin,
  output logic [2*XLEN:0] p_next
);

  logic            op_add;
  logic            op_sub;
  logic [XLEN-1:0] hi;
  logic            sgn;

  assign op_add = (p[1:0] == 2'b01);
  assign op_sub = (p[1:0] == 2'b10);

  assign add_b = op_sub ? ~m : m;
  assign cin   = op_sub;

  // Shift-in bit is the sign of the exact 33-bit sum, so a
  // multiplicand of -2^31 cannot flip the accumulator sign.
  always_comb begin
    hi  = p[2*XLEN:XLEN+1];
    sgn = p[2*XLEN];
    unique case (1'b1)
      op_add, op_sub: begin
        hi  = sum;
        sgn = sum[XLEN-1] ^ ovf;
      end
      default: ;
    endcase
  end

  assign p_next = {sgn, hi, p[XLEN:1]};

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, 32x32 signed, one step
// per cycle through a shared CLA adder; 33-cycle latency.
module booth_mult_seq
  import booth_mult_seq_pkg::*;
#(
  parameter int WIDTH = XLEN,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_mult,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  state_t             state;
  state_t             state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH:0]   p;
  logic [2*WIDTH:0]   p_next;
  logic [WIDTH-1:0]   m;
  logic [WIDTH-1:0]   add_b;
  logic [WIDTH-1:0]   sum;
  logic               cin;
  logic               cout;
  logic               ovf;
  logic               last;
  logic               unused_ok;

  assign last      = (cnt == CNT_W'(MULT_ITERS - 1));
  assign unused_ok = &{1'b0, cout};

  adder_32 u_add (
    .a    (p[2*WIDTH:WIDTH+1]),
    .b    (add_b),
    .cin  (cin),
    .sum  (sum),
    .cout (cout),
    .ovf  (ovf)
  );

  booth_step u_step (
    .p      (p),
    .m      (m),
    .sum    (sum),
    .ovf    (ovf),
    .add_b  (add_b),
    .cin    (cin),
    .p_next (p_next)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state: a start pulse always (re)starts an op.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (ctrl_mult) state_nx = RUN;
      RUN: begin
        if (ctrl_mult) state_nx = RUN;
        else if (last) state_nx = DONE;
      end
      DONE: state_nx = ctrl_mult ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand latch, shift register, counter and result capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      m              <= '0;
      p              <= '0;
      cnt            <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else if (ctrl_mult) begin
      m   <= data_operandA;
      p   <= {{WIDTH{1'b0}}, data_operandB, 1'b0};
      cnt <= '0;
    end else if (state == RUN) begin
      p   <= p_next;
      cnt <= cnt + 1'b1;
      if (last) begin
        data_result    <= p_next[WIDTH:1];
        data_exception <= (p_next[2*WIDTH:WIDTH+1]
                           != {WIDTH{p_next[WIDTH]}});
      end
    end
  end

  assign data_resultRDY = (state == DONE);

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed and random checks of booth_mult_seq.
// Inputs change at negedge or #1 after posedge; outputs read #1 after posedge.
module tb_booth_mult_seq;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ctrl_mult = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int nvec = 0;
  int nerr = 0;

  localparam int LIMIT = 40;

  booth_mult_seq dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_mult      (ctrl_mult),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  always #5 clock = ~clock;

  task automatic start(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    ctrl_mult     = 1'b1;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1;
    ctrl_mult     = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  // Edges after the start edge until RDY is seen (LIMIT on timeout).
  task automatic wait_rdy(output int n);
    n = 0;
    while (n < LIMIT) begin
      @(posedge clock);
      #1;
      n++;
      if (data_resultRDY) break;
    end
    if (!data_resultRDY) begin
      nvec++;
      nerr++;
      $display("FAIL rdy_timeout: no RDY within %0d cycles", LIMIT);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    nvec++;
    if (data_result !== 32'h0) begin
      nerr++;
      $display("FAIL reset_result: got %h want 0", data_result);
    end
    nvec++;
    if (data_exception !== 1'b0) begin
      nerr++;
      $display("FAIL reset_exc: got %b want 0", data_exception);
    end
    nvec++;
    if (data_resultRDY !== 1'b0) begin
      nerr++;
      $display("FAIL reset_rdy: got %b want 0", data_resultRDY);
    end
  endtask

  logic [31:0] va [6] = '{32'd5, 32'hFFFF_FFFD, 32'h0,
                          32'h8000_0000, 32'h0001_0000,
                          32'h7FFF_FFFF};
  logic [31:0] vb [6] = '{32'd7, 32'd6, 32'h8000_0000,
                          32'hFFFF_FFFF, 32'h0001_0000, 32'd1};
  logic [31:0] vr [6] = '{32'd35, 32'hFFFF_FFEE, 32'h0,
                          32'h8000_0000, 32'h0, 32'h7FFF_FFFF};
  logic        ve [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  // RDY rises on the 32nd edge after the start edge, i.e. in
  // the 33rd cycle counting the one the start edge opens.
  task automatic test_directed;
    int n;
    for (int i = 0; i < 6; i++) begin
      start(va[i], vb[i]);
      wait_rdy(n);
      nvec++;
      if (n !== 32) begin
        nerr++;
        $display("FAIL dir%0d_latency: got %0d want 32", i, n);
      end
      nvec++;
      if (data_result !== vr[i]) begin
        nerr++;
        $display("FAIL dir%0d_result: got %h want %h",
                 i, data_result, vr[i]);
      end
      nvec++;
      if (data_exception !== ve[i]) begin
        nerr++;
        $display("FAIL dir%0d_exc: got %b want %b",
                 i, data_exception, ve[i]);
      end
      @(posedge clock);
      #1;
      nvec++;
      if (data_resultRDY !== 1'b0) begin
        nerr++;
        $display("FAIL dir%0d_pulse: rdy still %b", i, data_resultRDY);
      end
    end
  endtask

  task automatic test_abort;
    int n;
    int early;
    early = 0;
    start(32'd2, 32'd3);
    repeat (9) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) early++;
    end
    start(32'd4, 32'd4);
    wait_rdy(n);
    nvec++;
    if (early !== 0 || n !== 32) begin
      nerr++;
      $display("FAIL abort_latency: early=%0d n=%0d want 0/32",
               early, n);
    end
    nvec++;
    if (data_result !== 32'd16) begin
      nerr++;
      $display("FAIL abort_result: got %h want 10", data_result);
    end
  endtask

  task automatic test_reset_mid_run;
    int seen;
    seen = 0;
    start(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (19) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    nvec++;
    if ({data_result, data_exception, data_resultRDY} !== 34'h0) begin
      nerr++;
      $display("FAIL midrst_outputs: got %h/%b/%b want 0/0/0",
               data_result, data_exception, data_resultRDY);
    end
    repeat (LIMIT) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) seen++;
    end
    nvec++;
    if (seen !== 0) begin
      nerr++;
      $display("FAIL midrst_no_rdy: got %0d pulses want 0", seen);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    start(32'd9, 32'd9);
    wait_rdy(n);
    ctrl_mult     = 1'b1;
    data_operandA = 32'd2;
    data_operandB = 32'd2;
    nvec++;
    if (data_result !== 32'd81) begin
      nerr++;
      $display("FAIL b2b_first: got %h want 51", data_result);
    end
    @(posedge clock);
    #1;
    ctrl_mult = 1'b0;
    data_operandA = 32'hDEAD_BEEF;
    wait_rdy(n);
    nvec++;
    if (n !== 32) begin
      nerr++;
      $display("FAIL b2b_latency: got %0d want 32", n);
    end
    nvec++;
    if (data_result !== 32'd4) begin
      nerr++;
      $display("FAIL b2b_second: got %h want 4", data_result);
    end
  endtask

  task automatic test_random;
    int          n;
    logic [31:0] a;
    logic [31:0] b;
    int          sa;
    int          sb;
    longint      prod;
    logic [63:0] pv;
    logic        e;
    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      b = $urandom;
      sa = a;
      sb = b;
      prod = longint'(sa) * longint'(sb);
      pv = prod;
      e = (pv[63:32] != {32{pv[31]}});
      start(a, b);
      wait_rdy(n);
      nvec++;
      if (data_result !== pv[31:0] || data_exception !== e) begin
        nerr++;
        $display("FAIL rand%0d %h*%h: got %h/%b want %h/%b",
                 i, a, b, data_result, data_exception, pv[31:0], e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_abort();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
